// File: rtl/rally_game_pkg.sv
// Shared definitions for the rally game: FSM state codes, player ids and
// width helpers used to size the position and divider registers.
package rally_game_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] ST_SERVE  = 3'd1;
   localparam logic [STATE_W-1:0] ST_MOVE_R = 3'd2;
   localparam logic [STATE_W-1:0] ST_MOVE_L = 3'd3;
   localparam logic [STATE_W-1:0] ST_POINT  = 3'd4;
   localparam logic [STATE_W-1:0] ST_OVER   = 3'd5;

   typedef enum logic {
      P1 = 1'b0,
      P2 = 1'b1
   } player_t;

   // Bits needed to hold the value n itself (used for divider counts).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rally_step_timer.sv
// Programmable step divider. Counts 0..div-1 while enabled and pulses step
// on the terminal count, then wraps. clr forces the count back to zero.
//   clk, reset (async, active low), en, clr, div -> step
module rally_step_timer
   import rally_game_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          clr,
   input  logic [DW-1:0] div,
   output logic          step
);

   logic [DW-1:0] cnt;
   logic          tc;

   // >= rather than == so a shrinking div can never strand the count above it.
   assign tc   = (cnt >= div - DW'(1));
   assign step = en & tc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + DW'(1);
      end
   end

endmodule

// File: rtl/rally_game.sv
// Two-player button rally game core. Moves a ball across an NPOS LED strip,
// detects hits, fouls and misses, keeps scores and alternates serve.
//   inputs : clk, reset (async, active low), p1, p2, kick (synchronised levels)
//   outputs: led strip, pos, sc1/sc2, state code, win1/win2/err pulses, over
//
// state   | meaning
// IDLE    | strip dark, waiting for kick
// SERVE   | ball parked at server's end, waiting for server's button
// MOVE_R  | ball travelling toward player 2
// MOVE_L  | ball travelling toward player 1
// POINT   | strip fully lit for one base step after a point
// OVER    | match finished, winner's half lit until kick
module rally_game
   import rally_game_pkg::*;
#(
   parameter int NPOS      = 8,
   parameter int TICK_DIV  = 25000000,
   parameter int MIN_DIV   = 3125000,
   parameter int SPEEDUP   = 1,
   parameter int WIN_SCORE = 5,
   parameter int SCW       = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    p1,
   input  logic                    p2,
   input  logic                    kick,
   output logic [NPOS-1:0]         led,
   output logic [$clog2(NPOS)-1:0] pos,
   output logic [SCW-1:0]          sc1,
   output logic [SCW-1:0]          sc2,
   output logic [2:0]              state,
   output logic                    win1,
   output logic                    win2,
   output logic                    err,
   output logic                    over
);

   localparam int PW = $clog2(NPOS);
   localparam int DW = cnt_width(TICK_DIV);
   localparam logic [PW-1:0]  POS_END  = PW'(NPOS - 1);
   localparam logic [DW-1:0]  DIV_BASE = DW'(TICK_DIV);
   localparam logic [DW-1:0]  DIV_MIN  = DW'(MIN_DIV);
   localparam logic [SCW-1:0] SC_WIN   = SCW'(WIN_SCORE);

   logic          p1_q, p2_q, kick_q;
   logic          p1_e, p2_e, kick_e;
   logic [2:0]    state_nx;
   logic          hit, award1, award2, foul;
   logic          at_end, at_start;
   logic          step, tmr_en, tmr_clr;
   logic [DW-1:0] cur_div, tmr_div, half_div, fast_div;
   player_t       server;

   assign p1_e   = p1 & ~p1_q;
   assign p2_e   = p2 & ~p2_q;
   assign kick_e = kick & ~kick_q;

   assign at_end   = (pos == POS_END);
   assign at_start = (pos == '0);

   assign half_div = cur_div >> 1;
   assign fast_div = (half_div < DIV_MIN) ? DIV_MIN : half_div;

   assign tmr_en  = (state == ST_MOVE_R) || (state == ST_MOVE_L) || (state == ST_POINT);
   assign tmr_div = (state == ST_POINT) ? DIV_BASE : cur_div;
   // Every hit is also a state change, so one clear covers both cases.
   assign tmr_clr = (state_nx != state);

   rally_step_timer #(.DW(DW)) u_timer (
      .clk   (clk),
      .reset (reset),
      .en    (tmr_en),
      .clr   (tmr_clr),
      .div   (tmr_div),
      .step  (step)
   );

   always_comb begin
      state_nx = state;
      hit      = 1'b0;
      award1   = 1'b0;
      award2   = 1'b0;
      foul     = 1'b0;
      case (state)
         ST_IDLE:  if (kick_e) state_nx = ST_SERVE;
         ST_SERVE: begin
            if (server == P1 && p1_e)      state_nx = ST_MOVE_R;
            else if (server == P2 && p2_e) state_nx = ST_MOVE_L;
         end
         ST_MOVE_R: begin
            // Receiver's edge outranks the step, so a press on the last
            // step cycle is still a return.
            if (p2_e) begin
               if (at_end) begin
                  hit      = 1'b1;
                  state_nx = ST_MOVE_L;
               end else begin
                  foul   = 1'b1;
                  award1 = 1'b1;
               end
            end else if (step && at_end) begin
               award1 = 1'b1;
            end
         end
         ST_MOVE_L: begin
            if (p1_e) begin
               if (at_start) begin
                  hit      = 1'b1;
                  state_nx = ST_MOVE_R;
               end else begin
                  foul   = 1'b1;
                  award2 = 1'b1;
               end
            end else if (step && at_start) begin
               award2 = 1'b1;
            end
         end
         ST_POINT: begin
            if (step) state_nx = (sc1 == SC_WIN || sc2 == SC_WIN) ? ST_OVER : ST_SERVE;
         end
         ST_OVER:  if (kick_e) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
      if (award1 || award2) state_nx = ST_POINT;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         pos     <= '0;
         sc1     <= '0;
         sc2     <= '0;
         win1    <= 1'b0;
         win2    <= 1'b0;
         err     <= 1'b0;
         server  <= P1;
         cur_div <= DIV_BASE;
         p1_q    <= 1'b0;
         p2_q    <= 1'b0;
         kick_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         win1   <= award1;
         win2   <= award2;
         err    <= foul;
         p1_q   <= p1;
         p2_q   <= p2;
         kick_q <= kick;
         if (award1 && sc1 != SC_WIN) sc1 <= sc1 + SCW'(1);
         if (award2 && sc2 != SC_WIN) sc2 <= sc2 + SCW'(1);
         if (award1) server <= P2;
         if (award2) server <= P1;
         if (hit && SPEEDUP != 0) cur_div <= fast_div;
         case (state)
            ST_IDLE: begin
               if (kick_e) begin
                  server  <= P1;
                  pos     <= '0;
                  cur_div <= DIV_BASE;
               end
            end
            ST_MOVE_R: if (step && !p2_e && !at_end)   pos <= pos + PW'(1);
            ST_MOVE_L: if (step && !p1_e && !at_start) pos <= pos - PW'(1);
            ST_POINT: begin
               if (state_nx == ST_SERVE) begin
                  pos     <= (server == P2) ? POS_END : '0;
                  cur_div <= DIV_BASE;
               end
            end
            ST_OVER: begin
               if (kick_e) begin
                  sc1 <= '0;
                  sc2 <= '0;
                  pos <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign over = (state == ST_OVER);

   always_comb begin
      led = '0;
      case (state)
         ST_SERVE, ST_MOVE_R, ST_MOVE_L: led[pos] = 1'b1;
         ST_POINT: led = '1;
         ST_OVER: begin
            // Odd NPOS: the middle LED falls in player 2's half.
            for (int i = 0; i < NPOS; i++)
               led[i] = (sc1 == SC_WIN) ? (i < NPOS / 2) : (i >= NPOS / 2);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rally_game.sv
module tb_rally_game;

   localparam int NPOS = 8, TICK_DIV = 4, MIN_DIV = 1, SPEEDUP = 1, WIN_SCORE = 2, SCW = 3;

   logic clk = 1'b0, reset = 1'b0, p1 = 1'b0, p2 = 1'b0, kick = 1'b0;
   logic [7:0] led;
   logic [2:0] pos, sc1, sc2, state;
   logic       win1, win2, err, over;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic       w1;
      logic       w2;
      logic       e;
      logic [2:0] s1;
      logic [2:0] s2;
   } pt_t;
   pt_t exp_q[$];

   always #5 clk = ~clk;

   rally_game #(
      .NPOS(NPOS), .TICK_DIV(TICK_DIV), .MIN_DIV(MIN_DIV), .SPEEDUP(SPEEDUP),
      .WIN_SCORE(WIN_SCORE), .SCW(SCW)
   ) dut (
      .clk(clk), .reset(reset), .p1(p1), .p2(p2), .kick(kick),
      .led(led), .pos(pos), .sc1(sc1), .sc2(sc2), .state(state),
      .win1(win1), .win2(win2), .err(err), .over(over)
   );

   // One-cycle press; returns at the negedge after the DUT reacted.
   task automatic press(input logic b1, input logic b2, input logic bk);
      p1 = b1; p2 = b2; kick = bk;
      @(negedge clk);
      p1 = 1'b0; p2 = 1'b0; kick = 1'b0;
   endtask

   task automatic wait_pos(input logic [2:0] target, output int cyc);
      cyc = 0;
      while (pos !== target && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic wait_point(output int cyc);
      cyc = 0;
      while (!(win1 === 1'b1 || win2 === 1'b1) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Counts POINT cycles including the current one; returns after leaving it.
   task automatic count_point(output int cyc);
      cyc = 1;
      @(negedge clk);
      while (state === 3'd4 && cyc < 50) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      int c;
      @(negedge clk);
      n_chk++; if (state !== 3'd0 || led !== 8'h00 || pos !== 3'd0) begin n_fail++;
         $display("FAIL reset_init: state=%0d led=%h pos=%0d expected 0/00/0", state, led, pos); end
      n_chk++; if (sc1 !== 3'd0 || sc2 !== 3'd0 || win1 !== 1'b0 || win2 !== 1'b0 || err !== 1'b0 || over !== 1'b0) begin n_fail++;
         $display("FAIL reset_init_outs: sc1=%0d sc2=%0d w1=%b w2=%b err=%b over=%b expected all 0", sc1, sc2, win1, win2, err, over); end
      reset = 1'b1;
      @(negedge clk);
      press(0, 0, 1);
      @(negedge clk);
      press(1, 0, 0);
      wait_pos(3'd5, c);
      n_chk++; if (state !== 3'd2 || pos !== 3'd5) begin n_fail++;
         $display("FAIL reset_setup: state=%0d pos=%0d expected 2/5", state, pos); end
      #2 reset = 1'b0;
      #1;
      n_chk++; if (state !== 3'd0 || pos !== 3'd0 || led !== 8'h00) begin n_fail++;
         $display("FAIL reset_async: state=%0d pos=%0d led=%h expected 0/0/00", state, pos, led); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_chk++; if (state !== 3'd0 || pos !== 3'd0 || led !== 8'h00 || sc1 !== 3'd0 || sc2 !== 3'd0) begin n_fail++;
         $display("FAIL reset_release: state=%0d pos=%0d led=%h sc=%0d/%0d expected zeros", state, pos, led, sc1, sc2); end
      n_chk++; if (win1 !== 1'b0 || win2 !== 1'b0 || err !== 1'b0) begin n_fail++;
         $display("FAIL reset_pulses: w1=%b w2=%b err=%b expected 0", win1, win2, err); end
   endtask

   task automatic test_serve_speed;
      int c;
      press(0, 0, 1);
      n_chk++; if (state !== 3'd1 || pos !== 3'd0 || led !== 8'h01) begin n_fail++;
         $display("FAIL serve_entry: state=%0d pos=%0d led=%h expected 1/0/01", state, pos, led); end
      press(0, 1, 0);
      n_chk++; if (state !== 3'd1) begin n_fail++;
         $display("FAIL serve_other_ignored: state=%0d expected 1", state); end
      press(1, 0, 0);
      n_chk++; if (state !== 3'd2 || led !== 8'h01) begin n_fail++;
         $display("FAIL serve_launch: state=%0d led=%h expected 2/01", state, led); end
      wait_pos(3'd7, c);
      n_chk++; if (c !== 28) begin n_fail++;
         $display("FAIL travel_base: got %0d clk expected 28", c); end
      press(0, 1, 0);
      n_chk++; if (state !== 3'd3 || pos !== 3'd7 || win1 !== 1'b0) begin n_fail++;
         $display("FAIL hit_p2: state=%0d pos=%0d w1=%b expected 3/7/0", state, pos, win1); end
      wait_pos(3'd6, c);
      n_chk++; if (c !== 2) begin n_fail++;
         $display("FAIL period_half: got %0d clk expected 2", c); end
      wait_pos(3'd0, c);
      n_chk++; if (c !== 12) begin n_fail++;
         $display("FAIL travel_half: got %0d clk expected 12", c); end
      press(1, 0, 0);
      n_chk++; if (state !== 3'd2) begin n_fail++;
         $display("FAIL hit_p1: state=%0d expected 2", state); end
      wait_pos(3'd1, c);
      n_chk++; if (c !== 1) begin n_fail++;
         $display("FAIL period_min: got %0d clk expected 1", c); end
      wait_pos(3'd7, c);
      n_chk++; if (c !== 6) begin n_fail++;
         $display("FAIL travel_min: got %0d clk expected 6", c); end
      press(0, 1, 0);
      n_chk++; if (state !== 3'd3 || win1 !== 1'b0 || sc1 !== 3'd0) begin n_fail++;
         $display("FAIL hit_on_step_min: state=%0d w1=%b sc1=%0d expected 3/0/0", state, win1, sc1); end
      wait_pos(3'd6, c);
      n_chk++; if (c !== 1) begin n_fail++;
         $display("FAIL period_stays_min: got %0d clk expected 1", c); end
   endtask

   task automatic test_miss;
      int  c;
      pt_t e;
      exp_q.push_back('{w1: 1'b0, w2: 1'b1, e: 1'b0, s1: 3'd0, s2: 3'd1});
      wait_point(c);
      n_chk++; if (c >= 200) begin n_fail++;
         $display("FAIL miss_timeout: waited %0d clk for point", c); end
      e = exp_q.pop_front();
      n_chk++; if (win1 !== e.w1 || win2 !== e.w2 || err !== e.e || sc1 !== e.s1 || sc2 !== e.s2) begin n_fail++;
         $display("FAIL miss_award: w1=%b w2=%b err=%b sc=%0d/%0d expected %b %b %b %0d/%0d",
                  win1, win2, err, sc1, sc2, e.w1, e.w2, e.e, e.s1, e.s2); end
      n_chk++; if (state !== 3'd4 || led !== 8'hFF) begin n_fail++;
         $display("FAIL miss_point: state=%0d led=%h expected 4/FF", state, led); end
      count_point(c);
      n_chk++; if (c !== 4) begin n_fail++;
         $display("FAIL point_len: got %0d clk expected 4", c); end
      n_chk++; if (state !== 3'd1 || pos !== 3'd0 || win2 !== 1'b0) begin n_fail++;
         $display("FAIL miss_reserve: state=%0d pos=%0d w2=%b expected 1/0/0", state, pos, win2); end
   endtask

   task automatic test_foul;
      int  c;
      pt_t e;
      press(0, 0, 1);
      n_chk++; if (state !== 3'd1) begin n_fail++;
         $display("FAIL kick_in_serve: state=%0d expected 1", state); end
      press(1, 0, 0);
      @(negedge clk);
      press(1, 0, 0);
      n_chk++; if (state !== 3'd2 || err !== 1'b0) begin n_fail++;
         $display("FAIL p1_ignored_mover: state=%0d err=%b expected 2/0", state, err); end
      wait_pos(3'd3, c);
      press(0, 0, 1);
      n_chk++; if (state !== 3'd2 || pos !== 3'd3) begin n_fail++;
         $display("FAIL kick_in_move: state=%0d pos=%0d expected 2/3", state, pos); end
      exp_q.push_back('{w1: 1'b1, w2: 1'b0, e: 1'b1, s1: 3'd1, s2: 3'd1});
      press(0, 1, 0);
      e = exp_q.pop_front();
      n_chk++; if (win1 !== e.w1 || win2 !== e.w2 || err !== e.e || sc1 !== e.s1 || sc2 !== e.s2) begin n_fail++;
         $display("FAIL foul_award: w1=%b w2=%b err=%b sc=%0d/%0d expected %b %b %b %0d/%0d",
                  win1, win2, err, sc1, sc2, e.w1, e.w2, e.e, e.s1, e.s2); end
      n_chk++; if (state !== 3'd4 || led !== 8'hFF) begin n_fail++;
         $display("FAIL foul_point: state=%0d led=%h expected 4/FF", state, led); end
      count_point(c);
      n_chk++; if (c !== 4) begin n_fail++;
         $display("FAIL foul_point_len: got %0d clk expected 4", c); end
      n_chk++; if (state !== 3'd1 || pos !== 3'd7 || led !== 8'h80) begin n_fail++;
         $display("FAIL foul_reserve: state=%0d pos=%0d led=%h expected 1/7/80", state, pos, led); end
   endtask

   task automatic test_simultaneous;
      int c;
      press(1, 0, 0);
      n_chk++; if (state !== 3'd1) begin n_fail++;
         $display("FAIL p2_serve_other: state=%0d expected 1", state); end
      press(0, 1, 0);
      n_chk++; if (state !== 3'd3 || led !== 8'h80) begin n_fail++;
         $display("FAIL p2_serve: state=%0d led=%h expected 3/80", state, led); end
      wait_pos(3'd0, c);
      n_chk++; if (c !== 28) begin n_fail++;
         $display("FAIL travel_reload: got %0d clk expected 28", c); end
      press(1, 0, 0);
      wait_pos(3'd7, c);
      n_chk++; if (c !== 14) begin n_fail++;
         $display("FAIL travel_half2: got %0d clk expected 14", c); end
      @(negedge clk);
      press(0, 1, 0);
      n_chk++; if (state !== 3'd3 || win1 !== 1'b0 || sc1 !== 3'd1) begin n_fail++;
         $display("FAIL hit_on_step: state=%0d w1=%b sc1=%0d expected 3/0/1", state, win1, sc1); end
      wait_pos(3'd0, c);
      press(1, 0, 0);
      n_chk++; if (state !== 3'd2) begin n_fail++;
         $display("FAIL hit_p1_min: state=%0d expected 2", state); end
      wait_pos(3'd7, c);
      press(1, 1, 0);
      n_chk++; if (state !== 3'd3 || err !== 1'b0 || win1 !== 1'b0 || win2 !== 1'b0) begin n_fail++;
         $display("FAIL both_edges: state=%0d err=%b w1=%b w2=%b expected 3/0/0/0", state, err, win1, win2); end
   endtask

   task automatic test_over;
      int  c;
      pt_t e;
      wait_pos(3'd0, c);
      press(1, 0, 0);
      n_chk++; if (state !== 3'd2) begin n_fail++;
         $display("FAIL over_setup: state=%0d expected 2", state); end
      exp_q.push_back('{w1: 1'b1, w2: 1'b0, e: 1'b0, s1: 3'd2, s2: 3'd1});
      wait_point(c);
      n_chk++; if (c >= 200) begin n_fail++;
         $display("FAIL over_timeout: waited %0d clk for point", c); end
      e = exp_q.pop_front();
      n_chk++; if (win1 !== e.w1 || win2 !== e.w2 || err !== e.e || sc1 !== e.s1 || sc2 !== e.s2) begin n_fail++;
         $display("FAIL match_award: w1=%b w2=%b err=%b sc=%0d/%0d expected %b %b %b %0d/%0d",
                  win1, win2, err, sc1, sc2, e.w1, e.w2, e.e, e.s1, e.s2); end
      count_point(c);
      n_chk++; if (state !== 3'd5 || over !== 1'b1 || led !== 8'h0F) begin n_fail++;
         $display("FAIL over_state: state=%0d over=%b led=%h expected 5/1/0F", state, over, led); end
      press(1, 0, 0);
      n_chk++; if (state !== 3'd5 || led !== 8'h0F) begin n_fail++;
         $display("FAIL over_p1_ignored: state=%0d led=%h expected 5/0F", state, led); end
      @(negedge clk);
      press(0, 0, 1);
      n_chk++; if (state !== 3'd0 || over !== 1'b0 || sc1 !== 3'd0 || sc2 !== 3'd0 || led !== 8'h00) begin n_fail++;
         $display("FAIL over_clear: state=%0d over=%b sc=%0d/%0d led=%h expected 0/0/0/0/00", state, over, sc1, sc2, led); end
   endtask

   initial begin
      test_reset();
      test_serve_speed();
      test_miss();
      test_foul();
      test_simultaneous();
      test_over();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rally_game.md
Name: rally_game

Overview:
- Parametrised successor of the two-player button rally game core.
- Moves a "ball" across an NPOS-position LED strip and detects hits, fouls and misses.
- Keeps both scores, alternates serve, and optionally speeds the ball up on every successful return.
- Drives the LED strip directly and exports score, state and event pulses to the display/scoreboard logic.

Parameters:
- NPOS, 8, number of ball positions / LEDs (>=4)
- TICK_DIV, 25000000, clk cycles per ball step at base speed
- MIN_DIV, 3125000, fastest allowed step period in clk cycles (1 <= MIN_DIV <= TICK_DIV)
- SPEEDUP, 1, 1 = halve step period on each return; 0 = constant speed
- WIN_SCORE, 5, points needed to win a match
- SCW, 3, score width; must hold WIN_SCORE

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- p1  in  1  player-1 button, level, already synchronised
- p2  in  1  player-2 button, level, already synchronised
- kick  in  1  start / clear button, level, already synchronised
- led  out  NPOS  strip drive
- pos  out  $clog2(NPOS)  current ball position
- sc1  out  SCW  player-1 score
- sc2  out  SCW  player-2 score
- state  out  3  current FSM state code
- win1  out  1  one-cycle pulse: point to player 1
- win2  out  1  one-cycle pulse: point to player 2
- err  out  1  one-cycle pulse: foul press
- over  out  1  high while the match is finished

Behaviour:
- Reset values (reset low, asynchronous): state=IDLE, sc1=sc2=0, pos=0, led=0, win1/win2/err=0, over=0, server=P1, cur_div=TICK_DIV, step timer=0, edge registers=0.
- Input edges: rising edges of p1, p2 and kick are detected internally, one-cycle internal pulses, 1 clk latency. Levels are ignored.
- Step timer: counts to cur_div-1, then emits a one-cycle step pulse and wraps to 0.
  - Cleared on every state entry and on every accepted hit.
  - Runs only in MOVE_R, MOVE_L and POINT.
  - POINT always uses TICK_DIV.
- Speed rule:
  - cur_div reloads to TICK_DIV on entry to SERVE.
  - On each accepted hit with SPEEDUP=1: cur_div = max(cur_div>>1, MIN_DIV).
- State codes: IDLE=0, SERVE=1, MOVE_R=2, MOVE_L=3, POINT=4, OVER=5.
- IDLE: led=0. kick edge -> SERVE, server=P1.
- SERVE: pos = 0 if server=P1, NPOS-1 if server=P2; led one-hot at pos.
  - Server's button edge -> MOVE_R (P1 serving) or MOVE_L (P2 serving).
  - Other player's edge: ignored.
- MOVE_R (ball travelling toward player 2): led one-hot at pos.
  - Step with pos<NPOS-1: pos+1.
  - p2 edge with pos==NPOS-1: hit -> MOVE_L, speed rule applied.
  - p2 edge with pos<NPOS-1: foul -> err pulse, point to P1.
  - Step with pos==NPOS-1 and no hit in that cycle: miss -> point to P1.
  - p1 edges: ignored.
- MOVE_L: mirror of MOVE_R (pos decrements, player 1 receives at pos==0, points go to P2).
- Simultaneous events in one cycle:
  - Receiver edge together with step at the end position: counts as a hit.
  - p1 and p2 edges together: only the receiver's edge is evaluated.
- Point award:
  - Scorer's counter increments, saturating at WIN_SCORE.
  - win1/win2 pulse in the award cycle.
  - server = the player who lost the point.
  - -> POINT.
- POINT: led all ones for exactly one base step, then:
  - OVER if either score == WIN_SCORE;
  - else SERVE.
- OVER: over=1; led = lower half lit if P1 won, upper half lit if P2 won (NPOS odd: middle LED belongs to P2).
  - kick edge: scores cleared, -> IDLE.
  - p1/p2 edges: ignored.
- kick edge in SERVE/MOVE/POINT: ignored (no mid-rally restart).
- Reset asserted in any state aborts immediately to reset values.
- pos width arithmetic never wraps: increments and decrements are gated by the end-position checks.

Decomposition:
- Shared package:
  - state enum and 3-bit codes
  - player id type (P1=0, P2=1)
  - clog2-based width constants
- Sub-module rally_step_timer: programmable divider with inputs clk, reset, en, clr, div; output step pulse. Reused for any future speed-mode variants.
- Edge detection, FSM, score counters and LED decode stay in rally_game.

Test Plan (NPOS=8, TICK_DIV=4, MIN_DIV=1, WIN_SCORE=2, SCW=3, SPEEDUP=1):
- Reset mid-MOVE_R at pos=5, release reset -> state=0, led=0, sc1=sc2=0, pos=0 next cycle; no win/err pulse.
- kick, then p1 edge -> state=2, led=8'h01. Ball reaches pos=7 after 7 steps (~28 clk). p2 edge at pos 7 -> state=3, next step period 2 clk. p1 hit at pos 0 -> period 1 clk, which then stays at 1.
- Rally in MOVE_R, p2 edge at pos=3 -> err=1 and win1=1 for one cycle, sc1=1, led=8'hFF for 4 clk, then SERVE with pos=7 (P2 serves).
- MOVE_L reaching pos=0, p1 never presses -> win2 pulse on the next step, sc2 increments, server=P1.
- p2 edge and step in the same cycle at pos=7 (MOVE_R) -> hit accepted, no point. p1 and p2 edges in the same cycle at pos=7 -> hit accepted, p1 edge ignored.
- P1 reaches 2 points -> after POINT, state=5, over=1, led=8'h0F. p1 edge ignored. kick edge -> sc1=sc2=0, state=0, over=0.
